// File: rtl/atanhx_12_hw_inv_if.sv
// Operand/result bundle for the atanh approximator: start/x_in into the
// pipeline, valid/y_out out of it.
interface atanhx_12_hw_inv_if #(
    parameter int DWIDTH = 32
) ();
    logic              start;
    logic [DWIDTH-1:0] x_in;
    logic              valid;
    logic [DWIDTH-1:0] y_out;

    modport master (
        output start,
        output x_in,
        input  valid,
        input  y_out
    );

    modport slave (
        input  start,
        input  x_in,
        output valid,
        output y_out
    );
endinterface

// File: rtl/atanhx_12_hw_inv.sv
// Pipelined piecewise-constant float32 atanh(y): classify, 12-way compare, encode, ROM.
// Define ATANHX_SAT_EN to saturate |y|>=1 and infinities to +/-max finite.
module atanhx_12_hw_inv #(
    parameter int                        K              = 12,
    parameter int                        DWIDTH         = 32,
    parameter int                        EXPONENT_WIDTH = 8,
    parameter logic [EXPONENT_WIDTH-1:0] BIAS           = 8'd127
) (
    input  logic                     clk,
    input  logic                     rst,
    atanhx_12_hw_inv_if.slave        bus
);
    localparam int AW = $clog2(K);
    localparam int EW = EXPONENT_WIDTH;
    localparam int MW = DWIDTH - 1 - EW;
    localparam int QW = 12;

    localparam logic [EW-1:0]     E_MAX    = '1;
    localparam logic [EW-1:0]     E_ONE    = 1;
    localparam logic [EW-1:0]     SEG_SPAN = 12;
    localparam logic [EW-1:0]     SMALL_E  = BIAS - SEG_SPAN;
    localparam logic [DWIDTH-1:0] QNAN     = 32'h7FC00000;
    localparam logic [DWIDTH-2:0] INF_MAG  = 31'h7F800000;
    localparam logic [DWIDTH-2:0] MAXF_MAG = 31'h7F7FFFFF;

    // q is |y| scaled by 4096; T[i] is the exclusive upper edge of segment i.
    localparam logic [QW:0] T [K] = '{
        13'd512,  13'd1024, 13'd1536, 13'd2048, 13'd2560, 13'd2816,
        13'd3072, 13'd3328, 13'd3584, 13'd3840, 13'd3968, 13'd4096
    };

    localparam logic [DWIDTH-1:0] ROM [K] = '{
        32'h3D8029F1, 32'h3E424B34, 32'h3EA588E3, 32'h3EF031CF,
        32'h3F22F05A, 32'h3F494467, 32'h3F67B15B, 32'h3F86378B,
        32'h3F9DF55A, 32'h3FC0C8DE, 32'h3FEEB35E, 32'h401B03B0
    };

    // Stage 1: input capture
    logic              s1_v_reg;
    logic [DWIDTH-1:0] s1_x_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_v_reg <= 1'b0;
            s1_x_reg <= '0;
        end else begin
            s1_v_reg <= bus.start;
            s1_x_reg <= bus.start ? bus.x_in : '0;
        end
    end

    // Stage 2: classification and comparator bank
    logic          s1_sign;
    logic [EW-1:0] s1_e;
    logic [MW-1:0] s1_m;
    logic          m_nz;

    assign s1_sign = s1_x_reg[DWIDTH-1];
    assign s1_e    = s1_x_reg[DWIDTH-2 -: EW];
    assign s1_m    = s1_x_reg[MW-1:0];
    assign m_nz    = |s1_m;

    logic              spec_next;
    logic [DWIDTH-1:0] spec_y_next;
    logic [QW-1:0]     q_next;
    logic [EW-1:0]     sh_next;
    logic [DWIDTH-1:0] inf_res;
    logic [DWIDTH-1:0] ovf_res;
    logic [DWIDTH-1:0] one_res;

`ifdef ATANHX_SAT_EN
    assign inf_res = {s1_sign, MAXF_MAG};
    assign ovf_res = {s1_sign, MAXF_MAG};
    assign one_res = {s1_sign, MAXF_MAG};
`else
    assign inf_res = QNAN;
    assign ovf_res = QNAN;
    assign one_res = {s1_sign, INF_MAG};
`endif

    always_comb begin
        spec_next   = 1'b0;
        spec_y_next = '0;
        q_next      = '0;
        sh_next     = '0;
        if (s1_e == E_MAX) begin
            spec_next   = 1'b1;
            spec_y_next = m_nz ? QNAN : inf_res;
        end else if (s1_e == '0) begin
            spec_next   = 1'b1;
            spec_y_next = {s1_sign, {(DWIDTH-1){1'b0}}};
        end else if ((s1_e > BIAS) || ((s1_e == BIAS) && m_nz)) begin
            spec_next   = 1'b1;
            spec_y_next = ovf_res;
        end else if (s1_e == BIAS) begin
            spec_next   = 1'b1;
            spec_y_next = one_res;
        end else if (s1_e < SMALL_E) begin
            spec_next   = 1'b1;
            spec_y_next = s1_x_reg;
        end else begin
            // Dropping mant[11] first turns a shift of (BIAS-e) into (BIAS-e-1)
            // with identical truncation, keeping q at 12 bits.
            sh_next = BIAS - s1_e - E_ONE;
            q_next  = {1'b1, s1_m[MW-1 -: QW-1]} >> sh_next;
        end
    end

    logic [K-1:0] c_next;

    genvar gi;
    generate
        for (gi = 0; gi < K; gi++) begin : g_cmp
            assign c_next[gi] = ({1'b0, q_next} < T[gi]);
        end
    endgenerate

    logic              s2_v_reg;
    logic              s2_sign_reg;
    logic              s2_spec_reg;
    logic [DWIDTH-1:0] s2_spec_y_reg;
    logic [K-1:0]      s2_c_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            s2_v_reg      <= 1'b0;
            s2_sign_reg   <= 1'b0;
            s2_spec_reg   <= 1'b0;
            s2_spec_y_reg <= '0;
            s2_c_reg      <= '0;
        end else begin
            s2_v_reg      <= s1_v_reg;
            s2_sign_reg   <= s1_v_reg & s1_sign;
            s2_spec_reg   <= s1_v_reg & spec_next;
            s2_spec_y_reg <= s1_v_reg ? spec_y_next : '0;
            s2_c_reg      <= s1_v_reg ? c_next : '0;
        end
    end

    // Stage 3: priority encoder, lowest set comparator wins
    logic [AW-1:0] a_next;

    always_comb begin
        a_next = AW'(K-1);
        for (int i = K-1; i >= 0; i--) begin
            if (s2_c_reg[i]) begin
                a_next = AW'(i);
            end
        end
    end

    logic              s3_v_reg;
    logic              s3_sign_reg;
    logic              s3_spec_reg;
    logic [DWIDTH-1:0] s3_spec_y_reg;
    logic [AW-1:0]     s3_a_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            s3_v_reg      <= 1'b0;
            s3_sign_reg   <= 1'b0;
            s3_spec_reg   <= 1'b0;
            s3_spec_y_reg <= '0;
            s3_a_reg      <= '0;
        end else begin
            s3_v_reg      <= s2_v_reg;
            s3_sign_reg   <= s2_v_reg & s2_sign_reg;
            s3_spec_reg   <= s2_v_reg & s2_spec_reg;
            s3_spec_y_reg <= s2_v_reg ? s2_spec_y_reg : '0;
            s3_a_reg      <= s2_v_reg ? a_next : '0;
        end
    end

    // Output register doubles as the registered ROM read
    logic              valid_reg;
    logic [DWIDTH-1:0] y_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_reg <= 1'b0;
            y_reg     <= '0;
        end else begin
            valid_reg <= s3_v_reg;
            if (!s3_v_reg) begin
                y_reg <= '0;
            end else if (s3_spec_reg) begin
                y_reg <= s3_spec_y_reg;
            end else begin
                y_reg <= {s3_sign_reg, ROM[s3_a_reg][DWIDTH-2:0]};
            end
        end
    end

    assign bus.valid = valid_reg;
    assign bus.y_out = y_reg;

    // Occupancy tracker; only feeds the assertion below
    typedef enum logic {IDLE, BUSY} mode_t;
    mode_t mode_reg;
    mode_t mode_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            mode_reg <= IDLE;
        end else begin
            mode_reg <= mode_next;
        end
    end

    always_comb begin
        mode_next = mode_reg;
        case (mode_reg)
            IDLE: if (s1_v_reg) mode_next = BUSY;
            BUSY: if (!(s1_v_reg || s2_v_reg || s3_v_reg || valid_reg)) mode_next = IDLE;
            default: mode_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (mode_reg == BUSY || !(s2_v_reg || s3_v_reg || valid_reg));
        end
    end
endmodule

// File: doc/atanhx_12_hw_inv.md
# atanhx_12_hw_inv

Pipelined single-precision atanh(y) approximator: the inverse-direction companion to the tanh approximator, mapping a tanh-domain value in (-1,1) back to the x domain. A 12-segment comparator bank, a priority encoder and a constant ROM produce a piecewise-constant result. Special operands are handled in a parallel classifier. Sits in the activation datapath wherever a tanh output must be un-squashed, e.g. for inverse-activation and calibration paths.

## Interface
- K, 12, number of magnitude segments (comparators and ROM entries)
- DWIDTH, 32, IEEE-754 word width
- EXPONENT_WIDTH, 8, exponent field width
- BIAS, 8'd127, exponent bias
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  reset, synchronous, active-high; clock clk
- start  in  1  qualifies x_in in the same cycle
- x_in  in  DWIDTH  operand y, float32
- valid  out  1  y_out holds a result this cycle
- y_out  out  DWIDTH  atanh(y), float32; 0 when valid=0

## Operation
- Stage 1 (input register): on each edge, capture x_in into s1_x and start into s1_v.
- Stage 2 (classify/compare): classification is performed in this priority order on e = exp field:
  - Exp=255 with mant≠0 is NaN, giving 0x7FC00000.
  - Exp=255 with mant=0 is ±inf, giving 0x7FC00000.
  - Exp=0 is zero or subnormal, giving {sign,31'b0}.
  - e>127, or e=127 with mant≠0, means |y|>1, giving 0x7FC00000.
  - e=127 with mant=0 means |y|=1, giving {sign,0x7F800000}.
  - e<115 is the small case, passed through unchanged: result = s2_x.
  - Otherwise (115≤e≤126): q[11:0] = {1'b1,mant[22:11]} >> (127−e), truncating; this is |y|·4096.
- Comparators: c[i] = (q < T[i]), registered. T = 512, 1024, 1536, 2048, 2560, 2816, 3072, 3328, 3584, 3840, 3968, 4096. Since q≤4095, c[11] is always 1.
- Stage 3 (encode/ROM/output): the lowest-index set c[i] gives address a. ROM[a] = 0.06258, 0.18974, 0.32331, 0.46913, 0.63648, 0.78620, 0.90505, 1.04857, 1.23405, 1.50613, 1.86485, 2.42210. Each entry is the nearest float32 of the listed value. y_out = {sign, ROM[a][30:0]}, unless the op was classified special, in which case y_out is the special result.
- Sign, special flag and special result travel with the data through every stage, with one register per stage.
- When start=0 the stage is a bubble: it produces valid=0 and y_out=0, and must not produce X.

## Timing
- Latency 3: start=1 sampled at edge N gives valid=1 and the result in the cycle after edge N+3.
- Throughput: one operand per cycle, fully pipelined, no stall and no backpressure.
- Valid pattern equals the start pattern delayed by 3 cycles; gaps are preserved exactly.
- Reset: all stage valid bits, valid and y_out are 0 after the reset edge.
- Reset mid-stream: in-flight ops are dropped and no valid appears for them.
- The first valid after rst deasserts is 3 cycles after the first sampled start.
- Mode tracking: a 2-state tracker uses IDLE (no valid in flight) and BUSY (any stage valid).
  - IDLE moves to BUSY when s1_v=1.
  - BUSY returns to IDLE when all stage valids are 0.
  - The tracker is internal and is used only for assertions.

## Configuration
- ATANHX_SAT_EN defined:
  - |y|=1, |y|>1 and ±inf return {sign,0x7F7FFFFF} (±max finite).
  - NaN still returns 0x7FC00000.
- ATANHX_SAT_EN undefined: the IEEE-like results given under Operation apply.

## Test plan
- Reset, then start=1 with x_in=0x3E99999A (0.3, q=1228, segment 2): valid after 3 cycles, y_out = float32(0.32331).
- Back-to-back stream of 0x3F000000 (0.5, q=2048, segment 4), 0xBF000000, 0x3F7C0000 (0.984375, q=4032, segment 11). Required response on 3 consecutive valid cycles, in the same order:
  - float32(0.63648)
  - float32(−0.63648)
  - float32(2.42210)
- Boundaries:
  - 0x3F800000 gives 0x7F800000.
  - 0xBF800000 gives 0xFF800000.
  - 0x40000000 gives 0x7FC00000.
  - 0x7FC00001 gives 0x7FC00000.
  - With ATANHX_SAT_EN defined, 0x3F800000 gives 0x7F7FFFFF.
- Small and zero:
  - 0x39000000 (2^-13) passes through unchanged.
  - 0x80000000 gives 0x80000000.
  - 0x00000001 gives 0x00000000.
- Segment edges, for each threshold T[i]<4096:
  - q=T[i]−1 selects segment i.
  - q=T[i] selects segment i+1.
  - Example: 0x3E000000 (0.125, q=512) gives float32(0.18974).
- Start pattern 1,0,1,1, then rst asserted for 1 cycle 2 edges later:
  - Only the first op produces valid.
  - valid and y_out are 0 from the reset edge until 3 cycles after the next start.
